// File: rtl/ll2_stream_arbiter.sv
// Round-robin burst arbiter: shares one actor output stream between NUM_IN producers,
// granting whole bursts of BURST_LEN tokens and releasing grants whose producer starves.
module ll2_stream_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 2,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_IN-1:0]        In_SEND,
    input  logic [NUM_IN*DATA_W-1:0] In_DATA,
    output logic [NUM_IN-1:0]        In_ACK,
    input  logic                     Out1_RDY,
    output logic                     Out1_SEND,
    output logic [DATA_W-1:0]        Out1_DATA,
    output logic [15:0]              Out1_COUNT,
    output logic [TAG_W-1:0]         Out1_TAG,
    output logic                     Out1_LAST,
    input  logic                     Out1_ACK,
    output logic                     ABORT
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] rr_ptr;
    logic [BW-1:0]    beat_cnt;
    logic [SW-1:0]    stall_cnt;

    logic [TAG_W-1:0]  pick;
    logic [TAG_W-1:0]  next_ptr;
    logic              g_send;
    logic [DATA_W-1:0] g_data;
    logic              xfer;
    logic              burst_end;
    logic              starved;
    logic              unused_ack;

    assign unused_ack = Out1_ACK;

    // Pick the requester closest to rr_ptr going upward (mod NUM_IN).
    always_comb begin
        int best;
        int d;
        best = NUM_IN;
        d    = 0;
        pick = rr_ptr;
        for (int i = 0; i < NUM_IN; i++) begin
            d = i - int'(rr_ptr);
            if (d < 0) d += NUM_IN;
            if (In_SEND[i] && d < best) begin
                best = d;
                pick = TAG_W'(i);
            end
        end
    end

    always_comb begin
        g_send = 1'b0;
        g_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == TAG_W'(i)) begin
                g_send = In_SEND[i];
                g_data = In_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr  = (grant == TAG_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
    assign xfer      = (state == GRANT) && g_send && Out1_RDY;
    assign burst_end = (beat_cnt == BW'(BURST_LEN - 1));
    assign starved   = (state == GRANT) && !g_send && (stall_cnt == SW'(TIMEOUT - 1));

    // Zero-latency passthrough: handshake and data follow the live inputs of the granted producer.
    always_comb begin
        In_ACK = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            In_ACK[i] = xfer && (grant == TAG_W'(i));
        end
    end

    assign Out1_SEND  = xfer;
    assign Out1_DATA  = xfer ? g_data : '0;
    assign Out1_TAG   = xfer ? grant : '0;
    assign Out1_LAST  = xfer && burst_end;
    assign Out1_COUNT = 16'h1;
    assign ABORT      = starved;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|In_SEND) begin
                        grant     <= pick;
                        state     <= GRANT;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (burst_end) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (!g_send) begin
                        if (starved) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ll2_stream_arbiter.sv
// Randomized bench for ll2_stream_arbiter against a transaction-level arbitration model.
module tb_ll2_stream_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int TW    = 2;
    localparam int BURST = 8;
    localparam int TOUT  = 16;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N-1:0]    In_SEND;
    logic [N*DW-1:0] In_DATA;
    logic [N-1:0]    In_ACK;
    logic            Out1_RDY;
    logic            Out1_SEND;
    logic [DW-1:0]   Out1_DATA;
    logic [15:0]     Out1_COUNT;
    logic [TW-1:0]   Out1_TAG;
    logic            Out1_LAST;
    logic            Out1_ACK;
    logic            ABORT;

    ll2_stream_arbiter #(
        .NUM_IN(N), .DATA_W(DW), .TAG_W(TW), .BURST_LEN(BURST), .TIMEOUT(TOUT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .In_SEND(In_SEND), .In_DATA(In_DATA), .In_ACK(In_ACK),
        .Out1_RDY(Out1_RDY), .Out1_SEND(Out1_SEND), .Out1_DATA(Out1_DATA),
        .Out1_COUNT(Out1_COUNT), .Out1_TAG(Out1_TAG), .Out1_LAST(Out1_LAST),
        .Out1_ACK(Out1_ACK), .ABORT(ABORT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: owner is the producer holding the stream (-1 while choosing),
    // sent counts tokens of the current burst, starve counts idle cycles of the owner.
    int owner  = -1;
    int sent   = 0;
    int starve = 0;
    int ptr    = 0;
    int n_last = 0;
    int n_abort = 0;

    logic [N-1:0] on_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_xfer();
        return owner >= 0 && In_SEND[owner] && Out1_RDY;
    endfunction

    task automatic compare_outputs();
        bit x;
        logic [N-1:0] e_ack;
        x = model_xfer();
        e_ack = '0;
        if (x) e_ack[owner] = 1'b1;
        chk("ack",   32'(In_ACK),    32'(e_ack));
        chk("send",  32'(Out1_SEND), 32'(x));
        chk("last",  32'(Out1_LAST), 32'(x && sent == BURST - 1));
        chk("abort", 32'(ABORT),     32'(owner >= 0 && !In_SEND[owner] && starve == TOUT - 1));
        chk("count", 32'(Out1_COUNT), 32'h1);
        if (x) begin
            chk("data", 32'(Out1_DATA), 32'(In_DATA[owner*DW +: DW]));
            chk("tag",  32'(Out1_TAG),  owner);
        end else begin
            chk("data_idle", 32'(Out1_DATA), 32'h0);
            chk("tag_idle",  32'(Out1_TAG),  32'h0);
        end
    endtask

    task automatic model_reset();
        owner = -1; sent = 0; starve = 0; ptr = 0;
    endtask

    task automatic model_step();
        bit x;
        x = model_xfer();
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (owner < 0 && In_SEND[(ptr + k) % N]) owner = (ptr + k) % N;
            end
            sent = 0;
            starve = 0;
        end else if (x) begin
            sent++;
            starve = 0;
            if (sent == BURST) begin
                n_last++;
                ptr = (owner + 1) % N;
                owner = -1;
            end
        end else if (!In_SEND[owner]) begin
            starve++;
            if (starve == TOUT) begin
                n_abort++;
                ptr = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) In_DATA[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        RESET    = 1'b0;
        In_SEND  = '1;
        Out1_RDY = 1'b1;
        Out1_ACK = 1'b0;
        on_mask  = '0;
        In_DATA  = '0;
        rand_data();
        model_reset();

        // Reset held with every producer requesting: outputs must stay quiet.
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); cyc++;
            rand_data();
            #1 compare_outputs();
            @(posedge CLK);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK); cyc++;
            RESET = 1'b1;
            rand_data();
            case (c / 500)
                0: begin In_SEND = '1; Out1_RDY = 1'b1; end
                1: begin In_SEND = 4'b0100; Out1_RDY = ($urandom_range(9, 0) < 8); end
                2, 4: begin
                    for (int i = 0; i < N; i++)
                        if ($urandom_range(19, 0) == 0) on_mask[i] = ~on_mask[i];
                    In_SEND  = on_mask;
                    Out1_RDY = ($urandom_range(9, 0) != 0);
                    if (c / 500 == 4 && $urandom_range(149, 0) == 0) RESET = 1'b0;
                end
                3: begin In_SEND = N'($urandom); Out1_RDY = $urandom_range(1, 0) == 1; end
                default: begin In_SEND = N'($urandom); Out1_RDY = 1'b1; end
            endcase
            if (!RESET) model_reset();
            #1 compare_outputs();
            @(posedge CLK);
            if (RESET) model_step();
        end

        chk("saw_last",  32'(n_last > 20), 32'h1);
        chk("saw_abort", 32'(n_abort > 0), 32'h1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
